// File: rtl/ror_seq_unit.sv
// Multi-cycle 16-bit rotate-right unit with start/done handshake.
// Optional macro ROR_FAST_EN selects the 4-stage logarithmic datapath.
module ror_seq_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] Rot_In,
    input  logic [3:0]  Rot_Val,
    output logic        busy,
    output logic        done,
    output logic [15:0] Rot_Out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_data;
    logic [3:0]  r_cnt;
    logic [15:0] r_rot_out;
    logic [15:0] w_next_data;
    logic        w_last;

`ifdef ROR_FAST_EN
    logic [3:0]  r_amt;

    // One logarithmic stage: rotate by 2^cnt when that amount bit is set.
    always_comb begin
        w_next_data = r_data;
        unique case (r_cnt[1:0])
            2'd0: if (r_amt[0]) w_next_data = {r_data[0],   r_data[15:1]};
            2'd1: if (r_amt[1]) w_next_data = {r_data[1:0], r_data[15:2]};
            2'd2: if (r_amt[2]) w_next_data = {r_data[3:0], r_data[15:4]};
            2'd3: if (r_amt[3]) w_next_data = {r_data[7:0], r_data[15:8]};
        endcase
        w_last = (r_cnt == 4'd3);
    end
`else
    // Serial datapath: one bit position per BUSY cycle.
    always_comb begin
        w_next_data = {r_data[0], r_data[15:1]};
        w_last      = (r_cnt == 4'd1);
    end
`endif

    // Control FSM, operand/counter registers and the held result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_data    <= 16'h0000;
            r_cnt     <= 4'd0;
            r_rot_out <= 16'h0000;
`ifdef ROR_FAST_EN
            r_amt     <= 4'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_data <= Rot_In;
`ifdef ROR_FAST_EN
                        // Fixed four stages regardless of amount.
                        r_amt   <= Rot_Val;
                        r_cnt   <= 4'd0;
                        r_state <= S_BUSY;
`else
                        r_cnt <= Rot_Val;
                        if (Rot_Val == 4'd0) begin
                            r_state   <= S_DONE;
                            r_rot_out <= Rot_In;
                        end else begin
                            r_state <= S_BUSY;
                        end
`endif
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    r_data <= w_next_data;
`ifdef ROR_FAST_EN
                    r_cnt  <= r_cnt + 4'd1;
`else
                    r_cnt  <= r_cnt - 4'd1;
`endif
                    if (w_last) begin
                        r_state   <= S_DONE;
                        r_rot_out <= w_next_data;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy    = (r_state == S_BUSY);
    assign done    = (r_state == S_DONE);
    assign Rot_Out = r_rot_out;

endmodule

// File: tb/tb_ror_seq_unit.sv
// Self-checking bench for ror_seq_unit against a behavioural rotate model.
// Expected latency and busy length follow ROR_FAST_EN when defined.
module tb_ror_seq_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] Rot_In;
    logic [3:0]  Rot_Val;
    logic        busy;
    logic        done;
    logic [15:0] Rot_Out;

    int checks = 0;
    int errors = 0;

    ror_seq_unit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .Rot_In  (Rot_In),
        .Rot_Val (Rot_Val),
        .busy    (busy),
        .done    (done),
        .Rot_Out (Rot_Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: rotate right by n with plain shifts.
    function automatic logic [15:0] model_ror(input logic [15:0] x, input int n);
        int k;
        k = n % 16;
        if (k == 0) return x;
        return (x >> k) | (x << (16 - k));
    endfunction

    function automatic int exp_lat(input int n);
`ifdef ROR_FAST_EN
        return 5;
`else
        return n + 1;
`endif
    endfunction

    function automatic int exp_busy(input int n);
`ifdef ROR_FAST_EN
        return 4;
`else
        return n;
`endif
    endfunction

    // Issue one operation; optionally start without waiting for a negedge
    // (used to start in the DONE cycle). Returns result, latency, busy cycles,
    // IDLE-gap cycles and overlap cycles. lat = -1 on timeout.
    task automatic run_op(input logic [15:0] x, input logic [3:0] n,
                          input bit wait_neg,
                          output logic [15:0] res, output int lat,
                          output int bcnt, output int gap, output int both);
        res = 16'h0; lat = -1; bcnt = 0; gap = 0; both = 0;
        if (wait_neg) @(negedge clk);
        start = 1'b1; Rot_In = x; Rot_Val = n;
        @(posedge clk);
        #1;
        start = 1'b0;
        Rot_In = 16'($urandom);
        Rot_Val = 4'($urandom);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (busy && done) both++;
            if (!busy && !done) gap++;
            if (done) begin
                lat = k;
                res = Rot_Out;
                break;
            end
        end
    endtask

    task automatic check_op(input string name, input logic [15:0] x,
                            input logic [3:0] n, input logic [15:0] res,
                            input int lat, input int bcnt, input int gap,
                            input int both);
        logic [15:0] e;
        e = model_ror(x, int'(n));
        checks++;
        if (lat < 0) begin
            errors++;
            $display("FAIL %s timeout: no done within 40 cycles", name);
            return;
        end
        if (res !== e) begin
            errors++;
            $display("FAIL %s result: got %h expected %h", name, res, e);
        end
        checks++;
        if (lat != exp_lat(int'(n))) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat(int'(n)));
        end
        checks++;
        if (bcnt != exp_busy(int'(n))) begin
            errors++;
            $display("FAIL %s busy cycles: got %0d expected %0d", name, bcnt, exp_busy(int'(n)));
        end
        checks++;
        if (gap != 0 || both != 0) begin
            errors++;
            $display("FAIL %s handshake: idle gap %0d overlap %0d expected 0 0", name, gap, both);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; Rot_In = 16'h0; Rot_Val = 4'h0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || Rot_Out !== 16'h0000) begin
            errors++;
            $display("FAIL reset: busy %b done %b out %h expected 0 0 0000", busy, done, Rot_Out);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || Rot_Out !== 16'h0000) begin
            errors++;
            $display("FAIL post_reset idle: busy %b done %b out %h expected 0 0 0000", busy, done, Rot_Out);
        end
    endtask

    task automatic test_plan_vectors();
        logic [15:0] r;
        int l, b, g, o;
        run_op(16'h8001, 4'd1, 1'b1, r, l, b, g, o);
        check_op("v8001_1", 16'h8001, 4'd1, r, l, b, g, o);
        run_op(16'h1234, 4'd4, 1'b1, r, l, b, g, o);
        check_op("v1234_4", 16'h1234, 4'd4, r, l, b, g, o);
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done %b expected 0", done);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (Rot_Out !== 16'h4123 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL hold_out: out %h busy %b done %b expected 4123 0 0", Rot_Out, busy, done);
        end
        run_op(16'hBEEF, 4'd0, 1'b1, r, l, b, g, o);
        check_op("vBEEF_0", 16'hBEEF, 4'd0, r, l, b, g, o);
    endtask

    task automatic test_ignore_start();
        logic [15:0] r;
        int l, b;
        l = -1; b = 0; r = 16'h0;
        @(negedge clk);
        start = 1'b1; Rot_In = 16'h0001; Rot_Val = 4'd15;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy) b++;
            if (k == 3) begin
                start = 1'b1; Rot_In = 16'hFFFF; Rot_Val = 4'd2;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                l = k; r = Rot_Out;
                break;
            end
        end
        start = 1'b0;
        check_op("v0001_15_ign", 16'h0001, 4'd15, r, l, b, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] r;
        int l, b, g, o;
        logic [15:0] x;
        logic [3:0]  n;
        run_op(16'hA5C3, 4'd3, 1'b1, r, l, b, g, o);
        check_op("b2b_first", 16'hA5C3, 4'd3, r, l, b, g, o);
        run_op(16'h00F0, 4'd8, 1'b0, r, l, b, g, o);
        check_op("b2b_00F0_8", 16'h00F0, 4'd8, r, l, b, g, o);
        for (int i = 0; i < 4; i++) begin
            x = 16'($urandom);
            n = 4'($urandom);
            run_op(x, n, 1'b0, r, l, b, g, o);
            check_op("b2b_rand", x, n, r, l, b, g, o);
        end
    endtask

    task automatic test_random();
        logic [15:0] r;
        int l, b, g, o;
        logic [15:0] x;
        logic [3:0]  n;
        for (int i = 0; i < 32; i++) begin
            x = 16'($urandom);
            n = (i < 16) ? 4'(i) : 4'($urandom);
            run_op(x, n, 1'b1, r, l, b, g, o);
            check_op("rand", x, n, r, l, b, g, o);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        start = 1'b1; Rot_In = 16'h1357; Rot_Val = 4'd10;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || Rot_Out !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset: busy %b done %b out %h expected 0 0 0000", busy, done, Rot_Out);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_reset quiet: active cycles %0d expected 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_plan_vectors();
        test_ignore_start();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_plan_vectors();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
